// File: rtl/bht_local_hist_pkg.sv
// Shared types and index helpers for the local-history branch history table.
package bht_local_hist_pkg;

  typedef struct packed {
    logic valid;
    logic taken;
  } bht_prediction_t;

  typedef enum logic {
    FLUSH_IDLE,
    FLUSH_RUN
  } flush_state_e;

  // Halfword bank inside a fetch row.
  function automatic int unsigned bht_bank(input logic [63:0] pc, input int unsigned bi);
    logic [63:0] t;
    t = (pc >> 1) & ((64'd1 << bi) - 64'd1);
    return t[31:0];
  endfunction

  // Row index sits just above the bank bits.
  function automatic int unsigned bht_row(input logic [63:0] pc, input int unsigned bi,
                                          input int unsigned ra);
    logic [63:0] t;
    t = (pc >> (1 + bi)) & ((64'd1 << ra) - 64'd1);
    return t[31:0];
  endfunction

endpackage

// File: rtl/bht_sat_counter.sv
// Saturating up/down counter step; optionally starts from the weakly-not-taken value.
module bht_sat_counter #(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] value,
  input  logic                use_init,
  input  logic                taken,
  output logic [CTR_BITS-1:0] result
);

  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;

  logic [CTR_BITS-1:0] start;

  always_comb begin
    start  = use_init ? CTR_INIT : value;
    result = start;
    if (taken) begin
      if (start != CTR_MAX) result = start + CTR_BITS'(1);
    end else begin
      if (start != '0) result = start - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/bht_local_hist.sv
// Branch history table with per-entry local history selecting a saturating counter;
// flop storage with single-cycle flush, or RAM storage with a row-by-row flush FSM.
module bht_local_hist
  import bht_local_hist_pkg::*;
#(
  parameter int unsigned VLEN            = 32,
  parameter int unsigned NR_ENTRIES      = 128,
  parameter int unsigned HIST_LEN        = 3,
  parameter int unsigned CTR_BITS        = 2,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter bit          FPGA_EN         = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       debug_mode_i,
  input  logic [VLEN-1:0]            vpc_i,
  input  logic                       update_valid_i,
  input  logic [VLEN-1:0]            update_pc_i,
  input  logic                       update_taken_i,
  output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
  output logic                       busy_o
);

  localparam int unsigned NR_ROWS = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned RA      = $clog2(NR_ROWS);
  localparam int unsigned BI      = $clog2(INSTR_PER_FETCH);
  localparam int unsigned RA_W    = (RA > 0) ? RA : 1;
  localparam int unsigned BI_W    = (BI > 0) ? BI : 1;
  localparam int unsigned NR_CTRS = 2 ** HIST_LEN;
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);

  typedef struct packed {
    logic                              valid;
    logic [HIST_LEN-1:0]               hist;
    logic [NR_CTRS-1:0][CTR_BITS-1:0]  ctr;
  } bht_entry_t;

  logic [63:0]         vpc_ext;
  logic [63:0]         upd_pc_ext;
  logic [RA_W-1:0]     rd_row;
  logic [RA_W-1:0]     upd_row;
  logic [BI_W-1:0]     upd_bank;
  logic                busy;
  logic                upd_en;
  logic                upd_fresh;
  bht_entry_t          bank_rd  [INSTR_PER_FETCH];
  bht_entry_t          bank_old [INSTR_PER_FETCH];
  bht_entry_t          upd_old;
  bht_entry_t          upd_entry;
  logic [HIST_LEN-1:0] hist_base;
  logic [CTR_BITS-1:0] ctr_cur;
  logic [CTR_BITS-1:0] ctr_new;

  assign vpc_ext    = 64'(vpc_i);
  assign upd_pc_ext = 64'(update_pc_i);
  assign rd_row     = RA_W'(bht_row(vpc_ext, BI, RA));
  assign upd_row    = RA_W'(bht_row(upd_pc_ext, BI, RA));
  assign upd_bank   = BI_W'(bht_bank(upd_pc_ext, BI));

  // Flush always wins over a same-cycle update.
  assign upd_en    = update_valid_i && !debug_mode_i && !busy && !flush_i;
  assign upd_old   = bank_old[upd_bank];
  assign upd_fresh = !upd_old.valid;
  assign hist_base = upd_fresh ? '0 : upd_old.hist;
  assign ctr_cur   = upd_old.ctr[hist_base];

  bht_sat_counter #(.CTR_BITS(CTR_BITS)) u_ctr (
    .value   (ctr_cur),
    .use_init(upd_fresh),
    .taken   (update_taken_i),
    .result  (ctr_new)
  );

  always_comb begin
    upd_entry = upd_old;
    if (upd_fresh) begin
      for (int i = 0; i < int'(NR_CTRS); i++) upd_entry.ctr[i] = CTR_WNT;
    end
    upd_entry.valid           = 1'b1;
    upd_entry.ctr[hist_base]  = ctr_new;
    upd_entry.hist            = HIST_LEN'({hist_base, update_taken_i});
  end

  for (genvar gi = 0; gi < INSTR_PER_FETCH; gi++) begin : g_pred
    bht_prediction_t pred;
    assign pred.valid       = bank_rd[gi].valid && !busy;
    assign pred.taken       = bank_rd[gi].ctr[bank_rd[gi].hist][CTR_BITS-1];
    assign pred_valid_o[gi] = pred.valid;
    assign pred_taken_o[gi] = pred.taken;
  end

  assign busy_o = busy;

  if (!FPGA_EN) begin : g_flop
    bht_entry_t mem [NR_ROWS][INSTR_PER_FETCH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int r = 0; r < int'(NR_ROWS); r++)
          for (int b = 0; b < int'(INSTR_PER_FETCH); b++) mem[r][b] <= '0;
      end else if (flush_i) begin
        for (int r = 0; r < int'(NR_ROWS); r++)
          for (int b = 0; b < int'(INSTR_PER_FETCH); b++) mem[r][b].valid <= 1'b0;
      end else if (upd_en) begin
        mem[upd_row][upd_bank] <= upd_entry;
      end
    end

    for (genvar gi = 0; gi < INSTR_PER_FETCH; gi++) begin : g_port
      assign bank_rd[gi]  = mem[rd_row][gi];
      assign bank_old[gi] = mem[upd_row][gi];
    end

    assign busy = 1'b0;
  end else begin : g_ram
    flush_state_e    state_reg;
    logic [RA_W-1:0] flush_row_reg;

    // RAM contents are undefined out of reset, so reset starts a full flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_reg     <= FLUSH_RUN;
        flush_row_reg <= '0;
      end else begin
        case (state_reg)
          FLUSH_IDLE: begin
            if (flush_i) begin
              state_reg     <= FLUSH_RUN;
              flush_row_reg <= '0;
            end
          end
          default: begin
            if (flush_i) begin
              flush_row_reg <= '0;
            end else if (flush_row_reg == RA_W'(NR_ROWS - 1)) begin
              state_reg     <= FLUSH_IDLE;
              flush_row_reg <= '0;
            end else begin
              flush_row_reg <= flush_row_reg + RA_W'(1);
            end
          end
        endcase
      end
    end

    assign busy = (state_reg == FLUSH_RUN);

    for (genvar gi = 0; gi < INSTR_PER_FETCH; gi++) begin : g_bank
      bht_entry_t      ram [NR_ROWS];
      bht_entry_t      rd_reg;
      logic            we;
      logic [RA_W-1:0] waddr;
      bht_entry_t      wdata;

      assign we    = busy || (upd_en && (upd_bank == BI_W'(gi)));
      assign waddr = busy ? flush_row_reg : upd_row;
      assign wdata = busy ? '0 : upd_entry;

      always_ff @(posedge clk_i) begin
        if (we) ram[waddr] <= wdata;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rd_reg <= '0;
        else         rd_reg <= ram[rd_row];
      end

      assign bank_rd[gi]  = rd_reg;
      assign bank_old[gi] = ram[upd_row];
    end
  end

endmodule

// File: tb/tb_bht_local_hist.sv
// Self-checking bench: flop-mode instance against a behavioural table model,
// plus directed checks of the sequential-flush instance.
module tb_bht_local_hist;

  localparam int ROWS = 64;
  localparam int IPF  = 2;
  localparam int NH   = 8;
  localparam int CMAX = 3;
  localparam int WNT  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        flush = 0, dbg = 0, uv = 0, ut = 0;
  logic [31:0] vpc = 0, upc = 0;
  logic [1:0]  pv, pt;
  logic        busy;

  logic        f_flush = 0, f_dbg = 0, f_uv = 0, f_ut = 0;
  logic [31:0] f_vpc = 0, f_upc = 0;
  logic [1:0]  f_pv, f_pt;
  logic        f_busy;

  bht_local_hist #(.FPGA_EN(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .debug_mode_i(dbg),
    .vpc_i(vpc), .update_valid_i(uv), .update_pc_i(upc), .update_taken_i(ut),
    .pred_valid_o(pv), .pred_taken_o(pt), .busy_o(busy)
  );

  bht_local_hist #(.FPGA_EN(1'b1)) dutf (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(f_flush), .debug_mode_i(f_dbg),
    .vpc_i(f_vpc), .update_valid_i(f_uv), .update_pc_i(f_upc), .update_taken_i(f_ut),
    .pred_valid_o(f_pv), .pred_taken_o(f_pt), .busy_o(f_busy)
  );

  int checks = 0;
  int failures = 0;

  bit m_valid [ROWS][IPF];
  int m_hist  [ROWS][IPF];
  int m_ctr   [ROWS][IPF][NH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_update(input logic [31:0] pc, input bit tk);
    int r, b, h;
    r = int'((pc >> 2) % 32'd64);
    b = int'((pc >> 1) % 32'd2);
    if (!m_valid[r][b]) begin
      m_valid[r][b] = 1'b1;
      m_hist[r][b]  = 0;
      for (int i = 0; i < NH; i++) m_ctr[r][b][i] = WNT;
    end
    h = m_hist[r][b];
    if (tk) m_ctr[r][b][h] = (m_ctr[r][b][h] < CMAX) ? m_ctr[r][b][h] + 1 : CMAX;
    else    m_ctr[r][b][h] = (m_ctr[r][b][h] > 0) ? m_ctr[r][b][h] - 1 : 0;
    m_hist[r][b] = (h * 2 + (tk ? 1 : 0)) % NH;
  endtask

  task automatic m_flush();
    for (int r = 0; r < ROWS; r++)
      for (int b = 0; b < IPF; b++) m_valid[r][b] = 1'b0;
  endtask

  task automatic check_pred(input string tag);
    logic [1:0] ev, et;
    int r;
    r = int'((vpc >> 2) % 32'd64);
    for (int b = 0; b < IPF; b++) begin
      ev[b] = m_valid[r][b];
      et[b] = (m_ctr[r][b][m_hist[r][b]] >= 2);
    end
    chk({tag, "_valid"}, 64'(pv), 64'(ev));
    chk({tag, "_taken"}, 64'(pt), 64'(et));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Called at #1 after a rising edge; the same-cycle lookup must see the old entry.
  task automatic do_update(input logic [31:0] pc, input bit tk, input bit dbg_m, input bit fl);
    upc = pc; ut = tk; uv = 1'b1; dbg = dbg_m; flush = fl; vpc = pc;
    #1;
    check_pred("pre_update");
    @(posedge clk); #1;
    if (fl) m_flush();
    else if (!dbg_m) m_update(pc, tk);
    uv = 1'b0; dbg = 1'b0; flush = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc, input string tag);
    vpc = pc;
    #1;
    check_pred(tag);
  endtask

  task automatic f_update(input logic [31:0] pc, input bit tk);
    f_upc = pc; f_ut = tk; f_uv = 1'b1;
    @(posedge clk); #1;
    f_uv = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [31:0] pc;
    for (int r = 0; r < ROWS; r++)
      for (int b = 0; b < IPF; b++) begin
        m_valid[r][b] = 1'b0;
        m_hist[r][b]  = 0;
        for (int i = 0; i < NH; i++) m_ctr[r][b][i] = 0;
      end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pred_valid", 64'(pv), 64'd0);
    chk("rst_pred_taken", 64'(pt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_f_busy", 64'(f_busy), 64'd1);
    chk("rst_f_pred_valid", 64'(f_pv), 64'd0);
    chk("rst_f_pred_taken", 64'(f_pt), 64'd0);
    rst_n = 1'b1;
    #1;
    cnt = 0;
    while (f_busy && cnt < 200) begin
      cnt++;
      @(posedge clk); #1;
    end
    chk("rst_f_busy_cycles", 64'(cnt), 64'd64);

    // Three taken updates from a fresh entry, then a fourth flips the prediction.
    repeat (3) do_update(32'h100, 1'b1, 1'b0, 1'b0);
    look(32'h100, "t3");
    chk("t3_bank0_valid", 64'(pv[0]), 64'd1);
    chk("t3_bank0_taken", 64'(pt[0]), 64'd0);
    do_update(32'h100, 1'b1, 1'b0, 1'b0);
    look(32'h100, "t4");
    chk("t4_bank0_taken", 64'(pt[0]), 64'd1);

    repeat (5) do_update(32'h40, 1'b0, 1'b0, 1'b0);
    look(32'h40, "sat_low");
    chk("sat_low_taken", 64'(pt[0]), 64'd0);

    repeat (8) do_update(32'h80, 1'b1, 1'b0, 1'b0);
    do_update(32'h80, 1'b0, 1'b0, 1'b0);
    repeat (3) do_update(32'h80, 1'b1, 1'b0, 1'b0);
    look(32'h80, "sat_high");
    chk("sat_high_taken", 64'(pt[0]), 64'd1);

    for (int i = 0; i < 16; i++) do_update(32'h202, (i % 2) == 0, 1'b0, 1'b0);
    look(32'h202, "alt");
    chk("alt_bank1_valid", 64'(pv[1]), 64'd1);
    chk("alt_bank0_taken", 64'(pt[0]), 64'd1);

    do_update(32'h10C, 1'b1, 1'b1, 1'b0);
    look(32'h10C, "debug");
    chk("debug_dropped", 64'(pv[0]), 64'd0);
    do_update(32'h10C, 1'b1, 1'b0, 1'b1);
    look(32'h10C, "flush_upd");
    chk("flush_upd_dropped", 64'(pv[0]), 64'd0);
    look(32'h100, "flush_clr");
    chk("flush_clr_valid", 64'(pv), 64'd0);

    for (int i = 0; i < 300; i++) begin
      pc = ($urandom & 32'hFFFF_FE00) | (32'($urandom_range(0, 3)) << 2) |
           (32'($urandom_range(0, 1)) << 1);
      do_update(pc, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                $urandom_range(0, 39) == 0);
      look($urandom & 32'h0000_003E, "rand_look");
    end

    // Sequential-flush instance: registered read, flush restart, busy drop.
    f_update(32'h100, 1'b1);
    f_vpc = 32'h104;
    @(posedge clk); #1;
    chk("f_other_row", 64'(f_pv), 64'd0);
    f_vpc = 32'h100;
    #1;
    chk("f_regread_lag", 64'(f_pv), 64'd0);
    @(posedge clk); #1;
    chk("f_regread_valid", 64'(f_pv), 64'd1);
    chk("f_regread_taken", 64'(f_pt), 64'd0);

    f_flush = 1'b1;
    @(posedge clk); #1;
    f_flush = 1'b0;
    chk("f_flush_busy", 64'(f_busy), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    f_upc = 32'h108; f_ut = 1'b1; f_uv = 1'b1;
    @(posedge clk); #1;
    f_uv = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    f_flush = 1'b1;
    @(posedge clk); #1;
    f_flush = 1'b0;
    cnt = 0;
    while (f_busy && cnt < 200) begin
      cnt++;
      @(posedge clk); #1;
    end
    chk("f_restart_cycles", 64'(cnt), 64'd64);
    f_vpc = 32'h108;
    @(posedge clk); #1;
    chk("f_busy_drop", 64'(f_pv), 64'd0);
    f_vpc = 32'h100;
    @(posedge clk); #1;
    chk("f_flush_cleared", 64'(f_pv), 64'd0);
    f_update(32'h108, 1'b1);
    f_vpc = 32'h108;
    @(posedge clk); #1;
    chk("f_post_flush_upd", 64'(f_pv), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bht_local_hist.md
Name: bht_local_hist

Overview:
- Parametrised successor to the fixed-geometry branch history table, generalised in four ways:
  - per-entry local history of HIST_LEN bits selecting one of 2^HIST_LEN saturating counters;
  - configurable counter width;
  - configurable fetch width (INSTR_PER_FETCH banks per row);
  - selectable storage mode: single-cycle flop flush, or FPGA-friendly sequential flush.
- Sits in the frontend, fed by the fetch PC; updated by resolved branches from the controller/branch unit.
- Sized from the core configuration (BHTEntries, BHTHist, FpgaEn, RVC).

Parameters:
- VLEN, 32, virtual address width.
- NR_ENTRIES, 128, total entries; power of 2, multiple of INSTR_PER_FETCH.
- HIST_LEN, 3, local history bits per entry; >= 1.
- CTR_BITS, 2, saturating counter width; >= 1.
- INSTR_PER_FETCH, 2, halfword-granular banks per fetch row; power of 2.
- FPGA_EN, 0, 0 = flop storage with combinational read; 1 = sequential flush with 1-cycle registered read.

Ports:
- clk_i, in, 1, clock.
- rst_ni, in, 1, asynchronous active-low reset.
- flush_i, in, 1, invalidate all entries.
- debug_mode_i, in, 1, suppresses updates.
- vpc_i, in, VLEN, fetch PC for lookup.
- update_valid_i, in, 1, resolved conditional branch strobe.
- update_pc_i, in, VLEN, PC of resolved branch.
- update_taken_i, in, 1, branch outcome.
- pred_valid_o, out, INSTR_PER_FETCH, per-bank entry valid.
- pred_taken_o, out, INSTR_PER_FETCH, per-bank taken prediction.
- busy_o, out, 1, flush in progress (FPGA_EN=1 only).

Behaviour:
- Derived values:
  - NR_ROWS = NR_ENTRIES/INSTR_PER_FETCH.
  - RA = log2(NR_ROWS); BI = log2(INSTR_PER_FETCH).
  - Row = pc[1+BI +: RA]; bank = pc[1 +: BI] (RVC halfword offset).
- Entry contents: valid; hist[HIST_LEN]; ctr[2^HIST_LEN][CTR_BITS].
- Prediction, bank b of row(vpc_i):
  - pred_valid_o[b] = valid && !busy_o.
  - pred_taken_o[b] = MSB of ctr[hist].
  - FPGA_EN=0: combinational, same cycle. FPGA_EN=1: outputs reflect the vpc_i of the previous cycle.
- Update: when update_valid_i && !debug_mode_i && !busy_o && !flush_i, the entry at (row, bank) of update_pc_i is written on the next edge.
  - If invalid: set valid=1, hist=0, all counters = weakly-not-taken (2^(CTR_BITS-1)-1), then apply the outcome below.
  - Counter at the current hist: +1 if taken, saturating at 2^CTR_BITS-1; -1 if not taken, saturating at 0.
  - Hist becomes {hist[HIST_LEN-2:0], taken}; for HIST_LEN=1, hist becomes taken.
  - One update per cycle.
- Lookup and update to the same entry in one cycle: lookup sees the pre-update value (no bypass).
- flush_i with update_valid_i in the same cycle: flush wins, update dropped.
- Flush, FPGA_EN=0: all valid bits cleared on the next edge; busy_o stays 0.
- Flush, FPGA_EN=1: FSM IDLE/FLUSH.
  - IDLE -> FLUSH on flush_i; row counter set to 0.
  - In FLUSH: clear valid of all banks of the counted row, increment; after row NR_ROWS-1, go to IDLE.
  - Duration: exactly NR_ROWS cycles. busy_o=1 in FLUSH.
  - flush_i during FLUSH restarts the counter at 0.
- Reset:
  - FPGA_EN=0: all valid=0, counters/hist=0, busy_o=0.
  - FPGA_EN=1: FSM enters FLUSH with counter 0 and busy_o=1, because RAM contents are undefined.
  - pred_valid_o=0 and pred_taken_o=0 in all modes.
  - Reset mid-flush restarts the flush.
- Widths: counter arithmetic is CTR_BITS wide with explicit saturation checks; no wrap.

Decomposition:
- Shared package (ariane_pkg/config side):
  - bht_entry_t struct parametrised by HIST_LEN/CTR_BITS;
  - bht_prediction_t {valid, taken};
  - helper functions for row/bank index extraction.
- One sub-module: bht_sat_counter (CTR_BITS-wide saturating inc/dec with init value), instantiated in the update path.
- Storage: flop array for FPGA_EN=0; inferred RAM wrapper for FPGA_EN=1.

Test Plan:
- Reset, FPGA_EN=0 -> pred_valid_o=0, busy_o=0. Reset, FPGA_EN=1, NR_ENTRIES=128, IPF=2 -> busy_o=1 for exactly 64 cycles, then 0.
- Update pc=0x100, taken, 3 times (HIST_LEN=3, CTR_BITS=2):
  - counters touched: ctr[0]=2, ctr[1]=2, ctr[3]=2; hist=3'b111.
  - vpc=0x100 -> bank0 valid=1, taken=0 (ctr[7]=1).
  - 4th taken update -> ctr[7]=2, hist=3'b111 -> taken=1.
- Repeated not-taken updates at hist=0, 5 cycles -> ctr[0] saturates at 0, no wrap to 3. Repeated taken at constant hist -> saturates at 3.
- Alternating T/N pattern at pc=0x202 for 16 updates -> predictions match the pattern after warm-up; bank1 (pc[1]=1) is updated, bank0 untouched.
- Update with debug_mode_i=1 -> entry unchanged. Update simultaneous with flush_i -> entry invalid afterwards. Update during busy_o -> dropped.
- FPGA_EN=1: flush_i at row 20 of an ongoing flush -> counter restarts at 0, busy_o lasts 64 more cycles. Registered read: vpc change appears on outputs one cycle later.
